fetch_unit: RTL and testbench

- Instruction fetch stage for the 16-bit CPU. It produces the instruction and next-PC pair that the decode stage consumes, and it takes back decode's resolved redirect (jump/branch target).
- Owns the PC register, issues word reads to instruction memory, and buffers returned instructions in a small in-order prefetch queue.
- Handles redirect flushes, including memory responses still in flight.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: the word width, the default reset PC,
// the prefetch queue entry layout and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned WordWidth = 16;

  typedef logic [WordWidth-1:0] word_t;

  localparam word_t DefaultResetPc = 16'h0000;

  // One prefetched instruction plus the address following it (link/branch base).
  typedef struct packed {
    word_t instr;
    word_t npc;
  } fq_entry_t;

  // StDrain means stale responses from before a redirect are still on their way back.
  typedef enum logic [0:0] {
    StRun,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction memory request/response channel and the
// decode-side instruction/redirect channel.
//   master : fetch unit side (drives imem_req/imem_addr and the instruction outputs)
//   slave  : environment side (memory and decode)
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // Instruction memory channel
  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  // Decode channel
  logic  redirect;
  word_t redirect_pc;
  logic  instr_valid;
  logic  instr_ready;
  word_t InstructOut;
  word_t NextPCOut;

  modport master (
    output imem_req, imem_addr, instr_valid, InstructOut, NextPCOut,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, InstructOut, NextPCOut,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous in-order FIFO with push, pop and flush.
//   clk_i/rst_ni          : clock, asynchronous active-low reset
//   push_i/push_data_i    : write one entry (a push on a full queue is accepted only
//                           together with a pop)
//   pop_i                 : drop the head entry (ignored when empty)
//   flush_i               : empty the queue; overrides push and pop in the same cycle
//   head_o                : current head entry (undefined when empty)
//   count_o/full_o/empty_o: occupancy
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [Width-1:0]           head_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != DepthC) || do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DepthC);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 16-bit CPU.
// Owns the PC, issues word reads to instruction memory, buffers returned words in an
// in-order prefetch queue and hands {instruction, address+1} pairs to decode. A redirect
// from decode flushes the queue and discards every response still in flight.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : fetch_unit_if.master (imem request/response, decode instruction/redirect)
// Optional build macro FETCH_PERF_EN adds saturating 16-bit counters:
//   perf_fetched (instructions popped), perf_flushed (redirects),
//   perf_stall (cycles with instr_valid & !instr_ready).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC = DefaultResetPc,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  fetch_unit_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]      perf_fetched,
  output logic [15:0]      perf_flushed,
  output logic [15:0]      perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW:0] QDepthC = (CntW + 1)'(QDEPTH);

  word_t           pc_q, pc_d;
  logic [CntW-1:0] discard_q, discard_d;
  fetch_state_e    state_q, state_d;
  logic            issue_en_q;

  logic            grant, rsp_valid;
  logic            q_push, q_pop, q_empty, q_full;
  logic [CntW-1:0] q_count, out_count;
  logic [CntW:0]   inflight;
  fq_entry_t       q_push_data, q_head;
  word_t           rsp_addr;
  logic            addr_empty, addr_full;
  logic            unused_full;

  // Addresses of granted requests, in order; its occupancy is the outstanding count.
  fetch_queue #(
    .Depth (QDEPTH),
    .Width (WordWidth)
  ) u_addr_q (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (grant),
    .push_data_i (pc_q),
    .pop_i       (bus.imem_rvalid),
    .flush_i     (1'b0),
    .head_o      (rsp_addr),
    .count_o     (out_count),
    .full_o      (addr_full),
    .empty_o     (addr_empty)
  );

  fetch_queue #(
    .Depth (QDEPTH),
    .Width ($bits(fq_entry_t))
  ) u_instr_q (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .flush_i     (bus.redirect),
    .head_o      (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // The issue cap counts buffered plus in-flight words, so a response can never find
  // the queue full.
  always_comb begin
    inflight     = {1'b0, q_count} + {1'b0, out_count};
    bus.imem_req = issue_en_q && !bus.redirect && (inflight < QDepthC);
    bus.imem_addr = pc_q;
    grant        = bus.imem_req && bus.imem_gnt;
    rsp_valid    = bus.imem_rvalid && !addr_empty;
  end

  always_comb begin
    q_push_data       = '0;
    q_push_data.instr = bus.imem_rdata;
    q_push_data.npc   = rsp_addr + 16'd1;
    q_push            = rsp_valid && (state_q == StRun);
    q_pop             = !q_empty && bus.instr_ready && !bus.redirect;

    bus.instr_valid = !q_empty;
    bus.InstructOut = q_empty ? '0 : q_head.instr;
    bus.NextPCOut   = q_empty ? '0 : q_head.npc;
  end

  // Everything in flight after a redirect cycle belongs to the abandoned path.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (bus.redirect) begin
      pc_d      = bus.redirect_pc;
      discard_d = out_count + CntW'(grant) - CntW'(rsp_valid);
    end else begin
      if (grant) pc_d = pc_q + 16'd1;
      if (rsp_valid && (state_q == StDrain)) discard_d = discard_q - 1'b1;
    end
    state_d = (discard_d != '0) ? StDrain : StRun;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      discard_q  <= '0;
      state_q    <= StRun;
      issue_en_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      state_q    <= state_d;
      issue_en_q <= 1'b1;
    end
  end

  assign unused_full = addr_full ^ q_full;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (q_pop && (perf_fetched != 16'hFFFF)) perf_fetched <= perf_fetched + 16'd1;
      if (bus.redirect && (perf_flushed != 16'hFFFF)) perf_flushed <= perf_flushed + 16'd1;
      if (!q_empty && !bus.instr_ready && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk;
  logic rst;
  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushed, perf_stall;
`endif

  fetch_unit #(
    .RESET_PC (16'h0000),
    .QDEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model knobs, set by the stimulus block.
  logic gnt_en = 1'b1;
  int   lat    = 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  // Instruction memory: decides gnt/rvalid at the falling edge, in-order responses
  // 'lat' cycles after the grant cycle.
  initial begin
    pend_t pend[$];
    int    mcyc;
    mcyc            = 0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (!rst) begin
        pend.delete();
        bus.imem_gnt = 1'b0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= mcyc) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend[0].addr);
          void'(pend.pop_front());
        end
        bus.imem_gnt = gnt_en;
        if (bus.imem_req && gnt_en) pend.push_back('{addr: bus.imem_addr, due: mcyc + lat});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next valid instruction, check it, let it pop.
  task automatic expect_instr(input string tag, input logic [15:0] ei, input logic [15:0] en);
    int n;
    n = 0;
    while (!bus.instr_valid && n < 30) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(bus.InstructOut), 32'(ei));
    check({tag, "_npc"}, 32'(bus.NextPCOut), 32'(en));
    step();
  endtask

  initial begin
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'h0000);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.InstructOut), 32'h0000);
    check("rst_npc", 32'(bus.NextPCOut), 32'h0000);
`ifdef FETCH_PERF_EN
    check("rst_perf", {perf_fetched, perf_flushed ^ perf_stall}, 32'd0);
`endif
    rst = 1'b1;

    // Streaming, latency 1: first valid two cycles after the first grant
    step();
    check("s_req0", 32'(bus.imem_req), 32'd1);
    check("s_addr0", 32'(bus.imem_addr), 32'h0000);
    check("s_valid0", 32'(bus.instr_valid), 32'd0);
    step();
    check("s_addr1", 32'(bus.imem_addr), 32'h0001);
    check("s_valid1", 32'(bus.instr_valid), 32'd0);
    step();
    check("s_valid2", 32'(bus.instr_valid), 32'd1);
    check("s_instr2", 32'(bus.InstructOut), 32'h1000);
    check("s_npc2", 32'(bus.NextPCOut), 32'h0001);
    check("s_addr2", 32'(bus.imem_addr), 32'h0002);
    step();
    check("s_instr3", 32'(bus.InstructOut), 32'h1001);
    check("s_npc3", 32'(bus.NextPCOut), 32'h0002);
    step();
    check("s_instr4", 32'(bus.InstructOut), 32'h1002);
    check("s_npc4", 32'(bus.NextPCOut), 32'h0003);

    // Decode stall: queue plus in-flight reaches QDEPTH, head holds
    bus.instr_ready = 1'b0;
    repeat (10) step();
    check("st_req", 32'(bus.imem_req), 32'd0);
    check("st_addr", 32'(bus.imem_addr), 32'h0006);
    check("st_valid", 32'(bus.instr_valid), 32'd1);
    check("st_instr", 32'(bus.InstructOut), 32'h1002);
    check("st_npc", 32'(bus.NextPCOut), 32'h0003);
    bus.instr_ready = 1'b1;
    step();
    expect_instr("rel3", 16'h1003, 16'h0004);
    expect_instr("rel4", 16'h1004, 16'h0005);
    expect_instr("rel5", 16'h1005, 16'h0006);
    expect_instr("rel6", 16'h1006, 16'h0007);

    // Park on 0x30 with grants withheld
    gnt_en          = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0030;
    step();
    bus.redirect = 1'b0;
    repeat (8) step();
    check("park_valid", 32'(bus.instr_valid), 32'd0);
    check("park_req", 32'(bus.imem_req), 32'd1);
    check("park_addr", 32'(bus.imem_addr), 32'h0030);

    // Latency 3, three grants in flight, redirect coincides with first rvalid
    lat    = 3;
    gnt_en = 1'b1;
    step();
    step();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    check("rd_req_forced", 32'(bus.imem_req), 32'd0);
    step();
    bus.redirect = 1'b0;
    #1;
    check("rd_valid_after", 32'(bus.instr_valid), 32'd0);
    check("rd_addr_after", 32'(bus.imem_addr), 32'h0040);
    expect_instr("rd40", 16'h1040, 16'h0041);
    expect_instr("rd41", 16'h1041, 16'h0042);
    expect_instr("rd42", 16'h1042, 16'h0043);

    // Back-to-back redirects: the last one wins
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    step();
    bus.redirect_pc = 16'h0200;
    step();
    bus.redirect = 1'b0;
    expect_instr("b2b200", 16'h1200, 16'h0201);
    expect_instr("b2b201", 16'h1201, 16'h0202);

    // PC wrap at 0xFFFF
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect = 1'b0;
    expect_instr("wrapFFFF", 16'h0FFF, 16'h0000);
    expect_instr("wrap0000", 16'h1000, 16'h0001);

    // Redirect while decode is stalled
    bus.instr_ready = 1'b0;
    repeat (3) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0050;
    step();
    bus.redirect = 1'b0;
    check("sr_valid", 32'(bus.instr_valid), 32'd0);
    bus.instr_ready = 1'b1;
    expect_instr("sr50", 16'h1050, 16'h0051);
`ifdef FETCH_PERF_EN
    check("perf_flushed", 32'(perf_flushed), 32'd6);
`endif

    // Reset mid-fetch with responses pending
    step();
    rst = 1'b0;
    #1;
    check("mr_req", 32'(bus.imem_req), 32'd0);
    check("mr_addr", 32'(bus.imem_addr), 32'h0000);
    check("mr_valid", 32'(bus.instr_valid), 32'd0);
    check("mr_instr", 32'(bus.InstructOut), 32'h0000);
    check("mr_npc", 32'(bus.NextPCOut), 32'h0000);
`ifdef FETCH_PERF_EN
    check("mr_perf", {perf_fetched, perf_flushed ^ perf_stall}, 32'd0);
`endif
    step();
    step();
    lat = 1;
    rst = 1'b1;
    expect_instr("mr0", 16'h1000, 16'h0001);
    expect_instr("mr1", 16'h1001, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
